// File: rtl/tube_event_capture_if.sv
// Write port toward the downstream event FIFO: data, strobe and full back-pressure.
interface tube_event_capture_if;
    logic [15:0] WR_DATA;
    logic        WR_EN;
    logic        WR_FULL;

    modport master (output WR_DATA, output WR_EN, input WR_FULL);
    modport slave  (input WR_DATA, input WR_EN, output WR_FULL);
endinterface

// File: rtl/tube_event_capture.sv
// Drift-tube hit capture: a scintillator trigger snapshots which tube channels were hit
// within the last WINDOW cycles and emits the 32-bit hit map as two 16-bit FIFO words.
module tube_event_capture #(
    parameter int WINDOW = 50
) (
    input  logic                        clk100,
    input  logic                        RST_N,
    input  logic                        SCIN_COIN,
    input  logic [7:0]                  TUBE3A,
    input  logic [7:0]                  TUBE3B,
    input  logic [7:0]                  TUBE4A,
    input  logic [7:0]                  TUBE4B,
    tube_event_capture_if.master        wr,
    output logic                        BUSY,
    output logic [7:0]                  DROP_CNT,
    output logic                        overflowLight
);
    localparam int AGE_W = $clog2(WINDOW + 1);
    localparam logic [AGE_W-1:0] AGE_LOAD = AGE_W'(WINDOW);
    localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WORD0 = 2'd1;
    localparam logic [1:0] ST_WORD1 = 2'd2;

    // Bit 32 is the trigger; bits 31:0 are tube channels in output-word order.
    logic [32:0] raw_in;
    logic [32:0] sync1_reg;
    logic [32:0] sync2_reg;
    logic [32:0] prev_reg;
    logic [32:0] edge_reg;
    logic [2:0]  warm_reg;
    logic [31:0] armed;
    logic [31:0] snap_reg;
    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [7:0]  drop_cnt_reg;
    logic        overflow_reg;
    logic        trig;
    logic        write_now;

    assign raw_in = {SCIN_COIN, TUBE3A, TUBE3B, TUBE4A, TUBE4B};

    // Edges are registered so trigger and tube edges stay aligned; warm_reg masks
    // edges until the chain holds real samples, so a line already high at release is ignored.
    always_ff @(posedge clk100 or negedge RST_N) begin
        if (!RST_N) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
            edge_reg  <= '0;
            warm_reg  <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            warm_reg  <= {warm_reg[1:0], 1'b1};
            edge_reg  <= warm_reg[2] ? (sync2_reg & ~prev_reg) : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_age
            logic [AGE_W-1:0] age_reg;

            always_ff @(posedge clk100 or negedge RST_N) begin
                if (!RST_N) begin
                    age_reg <= '0;
                end else if (edge_reg[gi]) begin
                    age_reg <= AGE_LOAD;
                end else if (age_reg != '0) begin
                    age_reg <= age_reg - AGE_ONE;
                end
            end

            assign armed[gi] = edge_reg[gi] | (age_reg != '0);
        end
    endgenerate

    assign trig = edge_reg[32];

    always_comb begin
        state_next = state_reg;
        write_now  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (trig) begin
                    state_next = ST_WORD0;
                end
            end
            ST_WORD0: begin
                if (!wr.WR_FULL) begin
                    write_now  = 1'b1;
                    state_next = ST_WORD1;
                end
            end
            ST_WORD1: begin
                if (!wr.WR_FULL) begin
                    write_now  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= ST_IDLE;
            snap_reg     <= '0;
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (trig && state_reg == ST_IDLE) begin
                snap_reg <= armed;
            end
            if (trig && state_reg != ST_IDLE) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != 8'hFF) begin
                    drop_cnt_reg <= drop_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign wr.WR_EN   = write_now;
    assign wr.WR_DATA = !write_now              ? 16'h0000 :
                        (state_reg == ST_WORD0) ? snap_reg[31:16] : snap_reg[15:0];

    assign BUSY          = (state_reg != ST_IDLE);
    assign DROP_CNT      = drop_cnt_reg;
    assign overflowLight = overflow_reg;
endmodule

// File: tb/tb_tube_event_capture.sv
// Bench for tube_event_capture: vector table, hand-written stall/reset sequences and
// a randomized run against a queue-based event model.
module tb_tube_event_capture;
    localparam int WINDOW = 50;
    localparam int NRAND  = 2500;

    typedef struct {
        logic [7:0]  t3a;
        logic [7:0]  t3b;
        logic [7:0]  t4a;
        logic [7:0]  t4b;
        int          gap;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    logic       clk100 = 1'b0;
    logic       RST_N;
    logic       SCIN_COIN;
    logic [7:0] TUBE3A, TUBE3B, TUBE4A, TUBE4B;
    logic       BUSY;
    logic [7:0] DROP_CNT;
    logic       overflowLight;

    int checks = 0;
    int errors = 0;

    vec_t vecs[7];

    // random-phase model state
    logic [32:0] cur_in, prev_in;
    int          last_rise[32];
    bit          trig_at[NRAND+16];
    logic [31:0] snap_at[NRAND+16];
    logic [15:0] wq[$];
    int          exp_drop;
    bit          exp_ovf;

    tube_event_capture_if wr_if();

    tube_event_capture #(.WINDOW(WINDOW)) dut (
        .clk100        (clk100),
        .RST_N         (RST_N),
        .SCIN_COIN     (SCIN_COIN),
        .TUBE3A        (TUBE3A),
        .TUBE3B        (TUBE3B),
        .TUBE4A        (TUBE4A),
        .TUBE4B        (TUBE4B),
        .wr            (wr_if),
        .BUSY          (BUSY),
        .DROP_CNT      (DROP_CNT),
        .overflowLight (overflowLight)
    );

    always #5 clk100 = ~clk100;

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nw, off0, off1;
        logic [15:0] d0, d1;
        nw = 0; off0 = -1; off1 = -1; d0 = '0; d1 = '0;
        for (int c = 0; c <= v.gap + 12; c++) begin
            tick();
            {TUBE3A, TUBE3B, TUBE4A, TUBE4B} = (c < 3) ? {v.t3a, v.t3b, v.t4a, v.t4b} : 32'h0;
            if (c == v.gap) SCIN_COIN = 1'b1;
            settle();
            if (wr_if.WR_EN) begin
                if (nw == 0) begin off0 = c - v.gap; d0 = wr_if.WR_DATA; end
                else if (nw == 1) begin off1 = c - v.gap; d1 = wr_if.WR_DATA; end
                nw++;
            end
        end
        SCIN_COIN = 1'b0;
        $display("vec%0d gap=%0d words=%0d w0=%04h w1=%04h lat=%0d", idx, v.gap, nw, d0, d1, off0);
        chk($sformatf("vec%0d_nwords", idx), nw, 2);
        chk($sformatf("vec%0d_latency0", idx), off0, 4);
        chk($sformatf("vec%0d_latency1", idx), off1, 5);
        chk($sformatf("vec%0d_word0", idx), d0, v.w0);
        chk($sformatf("vec%0d_word1", idx), d1, v.w1);
        chk($sformatf("vec%0d_drop", idx), DROP_CNT, 0);
        repeat (WINDOW + 10) tick();
    endtask

    task automatic run_stall();
        int nw, cy0, cy1;
        logic [15:0] d0, d1;
        nw = 0; cy0 = -1; cy1 = -1; d0 = '0; d1 = '0;
        for (int c = 0; c <= 30; c++) begin
            tick();
            case (c)
                0: begin SCIN_COIN = 1'b1; TUBE3A = 8'h81; TUBE4B = 8'h3C; end
                2: SCIN_COIN = 1'b0;
                3: begin TUBE3A = 8'h00; TUBE4B = 8'h00; end
                5: begin SCIN_COIN = 1'b1; TUBE3B = 8'hFF; end
                7: TUBE3B = 8'h00;
                10: SCIN_COIN = 1'b0;
                default: ;
            endcase
            wr_if.WR_FULL = (c >= 4 && c <= 8);
            settle();
            if (wr_if.WR_EN) begin
                if (nw == 0) begin cy0 = c; d0 = wr_if.WR_DATA; end
                else if (nw == 1) begin cy1 = c; d1 = wr_if.WR_DATA; end
                nw++;
            end
        end
        $display("stall words=%0d at %0d/%0d w0=%04h w1=%04h drop=%0d ovf=%0d",
                 nw, cy0, cy1, d0, d1, DROP_CNT, overflowLight);
        chk("stall_nwords", nw, 2);
        chk("stall_word0_cycle", cy0, 9);
        chk("stall_word1_cycle", cy1, 10);
        chk("stall_word0", d0, 16'h8100);
        chk("stall_word1", d1, 16'h003C);
        chk("stall_drop", DROP_CNT, 1);
        chk("stall_ovf", overflowLight, 1);
    endtask

    task automatic run_saturate();
        repeat (60) tick();
        wr_if.WR_FULL = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            SCIN_COIN = ~SCIN_COIN;
        end
        tick();
        SCIN_COIN = 1'b0;
        settle();
        $display("saturate drop=%0d busy=%0d", DROP_CNT, BUSY);
        chk("sat_drop", DROP_CNT, 255);
        chk("sat_busy", BUSY, 1);
        chk("sat_wr_en_full", wr_if.WR_EN, 0);
        wr_if.WR_FULL = 1'b0;
        repeat (70) tick();
        settle();
        chk("ovf_sticky", overflowLight, 1);
        chk("sat_idle", BUSY, 0);
        RST_N = 1'b0;
        #1;
        $display("async reset ovf=%0d drop=%0d", overflowLight, DROP_CNT);
        chk("reset_ovf", overflowLight, 0);
        chk("reset_drop", DROP_CNT, 0);
        tick();
        RST_N = 1'b1;
        repeat (6) tick();
    endtask

    task automatic run_midreset();
        int nw;
        nw = 0;
        tick();
        SCIN_COIN = 1'b1;
        TUBE3A = 8'h01;
        wr_if.WR_FULL = 1'b1;
        repeat (5) tick();
        settle();
        chk("midreset_busy_before", BUSY, 1);
        wr_if.WR_FULL = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("midreset_wr_en", wr_if.WR_EN, 0);
        chk("midreset_wr_data", wr_if.WR_DATA, 0);
        chk("midreset_busy", BUSY, 0);
        tick();
        tick();
        RST_N = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            settle();
            if (wr_if.WR_EN) nw++;
        end
        $display("midreset words_after_release=%0d busy=%0d", nw, BUSY);
        chk("midreset_no_write", nw, 0);
        chk("midreset_idle", BUSY, 0);
        SCIN_COIN = 1'b0;
        TUBE3A = 8'h00;
    endtask

    task automatic run_random();
        logic [31:0] mask, armed;
        logic        exp_en;
        logic [15:0] exp_data;
        RST_N = 1'b0;
        SCIN_COIN = 1'b0;
        {TUBE3A, TUBE3B, TUBE4A, TUBE4B} = 32'h0;
        wr_if.WR_FULL = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        repeat (6) tick();
        prev_in = '0;
        exp_drop = 0;
        exp_ovf = 1'b0;
        wq.delete();
        for (int ch = 0; ch < 32; ch++) last_rise[ch] = -100000;
        for (int k = 0; k < NRAND + 16; k++) begin trig_at[k] = 1'b0; snap_at[k] = '0; end
        for (int c = 0; c < NRAND + 12; c++) begin
            tick();
            if (c < NRAND) begin
                mask = $urandom & $urandom & $urandom & $urandom;
                {TUBE3A, TUBE3B, TUBE4A, TUBE4B} = {TUBE3A, TUBE3B, TUBE4A, TUBE4B} ^ mask;
                if ($urandom_range(0, 4) == 0) SCIN_COIN = ~SCIN_COIN;
                wr_if.WR_FULL = ($urandom_range(0, 3) == 0);
            end else begin
                {TUBE3A, TUBE3B, TUBE4A, TUBE4B} = 32'h0;
                SCIN_COIN = 1'b0;
                wr_if.WR_FULL = 1'b0;
            end
            cur_in = {SCIN_COIN, TUBE3A, TUBE3B, TUBE4A, TUBE4B};
            for (int ch = 0; ch < 32; ch++)
                if (cur_in[ch] && !prev_in[ch]) last_rise[ch] = c;
            // hit map is decided by rise times relative to this trigger rise
            if (cur_in[32] && !prev_in[32]) begin
                armed = '0;
                for (int ch = 0; ch < 32; ch++)
                    if (c - last_rise[ch] <= WINDOW) armed[ch] = 1'b1;
                trig_at[c+3] = 1'b1;
                snap_at[c+3] = armed;
            end
            prev_in = cur_in;
            settle();
            exp_en   = (wq.size() > 0) && !wr_if.WR_FULL;
            exp_data = exp_en ? wq[0] : 16'h0000;
            if (wr_if.WR_EN) $display("rand cyc=%0d write %04h", c, wr_if.WR_DATA);
            chk($sformatf("rand%0d_wr_en", c), wr_if.WR_EN, exp_en);
            chk($sformatf("rand%0d_wr_data", c), wr_if.WR_DATA, exp_data);
            chk($sformatf("rand%0d_busy", c), BUSY, (wq.size() > 0));
            chk($sformatf("rand%0d_drop", c), DROP_CNT, exp_drop);
            chk($sformatf("rand%0d_ovf", c), overflowLight, exp_ovf);
            if (trig_at[c]) begin
                if (wq.size() > 0) begin
                    if (exp_drop < 255) exp_drop++;
                    exp_ovf = 1'b1;
                end else begin
                    wq.push_back(snap_at[c][31:16]);
                    wq.push_back(snap_at[c][15:0]);
                end
            end
            if (exp_en) void'(wq.pop_front());
        end
    endtask

    initial begin
        vecs[0] = '{8'h10, 8'h00, 8'h00, 8'h00,  6, 16'h1000, 16'h0000};
        vecs[1] = '{8'h10, 8'h08, 8'h02, 8'h01,  5, 16'h1008, 16'h0201};
        vecs[2] = '{8'h10, 8'h00, 8'h00, 8'h00, 60, 16'h0000, 16'h0000};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h80, WINDOW, 16'h0000, 16'h0080};
        vecs[4] = '{8'h00, 8'h00, 8'h01, 8'h00, WINDOW + 1, 16'h0000, 16'h0000};
        vecs[5] = '{8'h00, 8'hFF, 8'h00, 8'h00,  0, 16'h00FF, 16'h0000};
        vecs[6] = '{8'h00, 8'h00, 8'h00, 8'h00,  4, 16'h0000, 16'h0000};

        RST_N = 1'b0;
        SCIN_COIN = 1'b0;
        {TUBE3A, TUBE3B, TUBE4A, TUBE4B} = 32'h0;
        wr_if.WR_FULL = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            SCIN_COIN = $urandom_range(0, 1) == 1;
            {TUBE3A, TUBE3B, TUBE4A, TUBE4B} = $urandom;
            wr_if.WR_FULL = $urandom_range(0, 1) == 1;
            settle();
            chk($sformatf("reset%0d_outputs", i),
                {wr_if.WR_EN, wr_if.WR_DATA, BUSY, DROP_CNT, overflowLight}, 0);
        end
        SCIN_COIN = 1'b0;
        {TUBE3A, TUBE3B, TUBE4A, TUBE4B} = 32'h0;
        wr_if.WR_FULL = 1'b0;
        tick();
        RST_N = 1'b1;
        repeat (6) tick();
        settle();
        $display("reset released busy=%0d drop=%0d", BUSY, DROP_CNT);
        chk("idle_after_reset", BUSY, 0);

        foreach (vecs[i]) run_vec(i, vecs[i]);
        run_stall();
        run_saturate();
        run_midreset();
        run_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
